branch_sequencer: RTL and testbench
===================================

// Module: branch_sequencer
// PURPOSE
//  Program-counter sequencer that drives the branch-target lookup table.
//  Steps the PC through instruction fetch and presents the branch index to the LUT.
//  On a taken branch, it loads the LUT-supplied absolute target into the PC.
//  Runs a Start/Done handshake with the top-level test harness, counts executed cycles,
//  and flags branch indices that address unpopulated LUT entries.
// PARAMETERS
//  PC_W        10  width of ProgCtr and LutTarget
//  LUT_AW      4   width of branch index / LUT address
//  MAX_LUT_IDX 8   highest populated LUT entry; larger indices are illegal
//  RESET_PC    0   PC value loaded on reset and on every Start
//  CNT_W       16  width of the cycle counter
// PORTS
//  Clk        in   1       single clock, rising edge
//  Reset_n    in   1       asynchronous, active-low reset
//  Start      in   1       one-cycle pulse; begins a program run
//  Halt       in   1       decoded halt instruction at current PC
//  BranchEn   in   1       current instruction is a branch
//  BranchCond in   1       branch condition true (taken when BranchEn&BranchCond)
//  BranchIdx  in   LUT_AW  LUT index carried by the branch instruction
//  LutAddr    out  LUT_AW  address to LUT (combinational copy of BranchIdx)
//  LutTarget  in   PC_W    target returned by LUT (combinational, same cycle)
//  ProgCtr    out  PC_W    current program counter (registered)
//  Running    out  1       high while state==RUN
//  Done       out  1       high while state==DONE
//  BadTarget  out  1       high while state==ERR
//  CycleCnt   out  CNT_W   number of RUN cycles in the current/last run
// BEHAVIOUR
//  Reset (Reset_n=0, async): state=IDLE, ProgCtr=RESET_PC, CycleCnt=0, all flags 0.
//  Reset mid-run aborts immediately to the same values; there is no resume.
//  States: IDLE, RUN, DONE, ERR. Flags are decoded from the registered state
//  (no glitches, 0-cycle latency from state).
//  IDLE/DONE/ERR + Start: next state=RUN, ProgCtr<=RESET_PC, CycleCnt<=0.
//  IDLE/DONE/ERR without Start: hold all registers.
//  RUN: each cycle, CycleCnt<=CycleCnt+1, saturating at all-ones.
//   Only one action applies per cycle, chosen in priority order:
//   1 Halt=1 -> DONE; ProgCtr holds (points at the halt instruction).
//   2 taken branch with BranchIdx > MAX_LUT_IDX -> ERR; ProgCtr holds.
//   3 taken branch, legal index -> ProgCtr<=LutTarget (absolute, 1-cycle).
//   4 otherwise -> ProgCtr<=ProgCtr+1, modulo 2^PC_W (all-ones wraps to 0).
//  Halt and BranchIdx are ignored outside RUN.
//  Start while in RUN is ignored (no restart).
//  BranchEn=1 with BranchCond=0 behaves as a plain increment.
//  The index legality check is made only for taken branches.
//  LutAddr = BranchIdx in every state, so the LUT is always addressed.
//  LutTarget is sampled only on a taken legal branch.
//  The block adds no pipeline delay: the new PC is visible the cycle after the decision.
// TESTING
//  1 Reset: Reset_n=0 asynchronously mid-run at PC=0x005
//    -> ProgCtr=0, IDLE, CycleCnt=0, no flags, without waiting for a clock edge.
//  2 Sequential: Start, 5 cycles with no branch and no halt
//    -> ProgCtr 0,1,2,3,4,5; CycleCnt=5; Running=1.
//  3 Branch: in RUN, BranchEn=BranchCond=1, BranchIdx=3, LutTarget=0x1A4
//    -> ProgCtr=0x1A4 next cycle.
//    With BranchCond=0 instead -> ProgCtr increments.
//  4 Bad index: taken branch with BranchIdx=9 -> BadTarget=1 and ProgCtr holds.
//    A following Start -> RUN at PC=0.
//  5 Halt priority: Halt=1 together with a taken branch at PC=0x010
//    -> DONE, ProgCtr=0x010, Done held.
//    Start while in RUN is ignored.
//  6 Wrap/saturation: force ProgCtr=0x3FF and increment -> 0x000.
//    Run with CNT_W=4 for 20 cycles -> CycleCnt sticks at 0xF.

Source files
------------

// File: rtl/branch_sequencer_if.sv
// Handshake and LUT bus between the branch sequencer and its test harness.
// The harness (master) drives control/instruction decode and the LUT result;
// the sequencer (slave) drives the LUT address, PC, status flags and counter.
interface branch_sequencer_if #(
    parameter int PC_W   = 10,
    parameter int LUT_AW = 4,
    parameter int CNT_W  = 16
);
    logic              Start;
    logic              Halt;
    logic              BranchEn;
    logic              BranchCond;
    logic [LUT_AW-1:0] BranchIdx;
    logic [LUT_AW-1:0] LutAddr;
    logic [PC_W-1:0]   LutTarget;
    logic [PC_W-1:0]   ProgCtr;
    logic              Running;
    logic              Done;
    logic              BadTarget;
    logic [CNT_W-1:0]  CycleCnt;

    modport master (
        output Start, Halt, BranchEn, BranchCond, BranchIdx, LutTarget,
        input  LutAddr, ProgCtr, Running, Done, BadTarget, CycleCnt
    );

    modport slave (
        input  Start, Halt, BranchEn, BranchCond, BranchIdx, LutTarget,
        output LutAddr, ProgCtr, Running, Done, BadTarget, CycleCnt
    );
endinterface

// File: rtl/branch_sequencer.sv
// Program-counter sequencer for the branch-target LUT. Steps the PC during a
// run, loads absolute LUT targets on taken branches, stops on halt or on an
// out-of-range branch index, and counts (saturating) the cycles spent running.
module branch_sequencer #(
    parameter int PC_W        = 10,
    parameter int LUT_AW      = 4,
    parameter int MAX_LUT_IDX = 8,
    parameter int RESET_PC    = 0,
    parameter int CNT_W       = 16
) (
    input  logic                Clk,
    input  logic                Reset_n,
    branch_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             taken;

    assign taken = bus.BranchEn & bus.BranchCond;

    // State, PC and cycle counter registers; reset aborts any run at once.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            pc_q    <= PC_W'(RESET_PC);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state, PC and counter update; one PC action per RUN cycle by priority.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (bus.Start) begin
                    state_d = RUN;
                    pc_d    = PC_W'(RESET_PC);
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (bus.Halt) begin
                    state_d = DONE;
                end else if (taken && (bus.BranchIdx > LUT_AW'(MAX_LUT_IDX))) begin
                    state_d = ERR;
                end else if (taken) begin
                    pc_d = bus.LutTarget;
                end else begin
                    pc_d = pc_q + PC_W'(1);
                end
            end
        endcase
    end

    assign bus.LutAddr   = bus.BranchIdx;
    assign bus.ProgCtr   = pc_q;
    assign bus.CycleCnt  = cnt_q;
    assign bus.Running   = (state_q == RUN);
    assign bus.Done      = (state_q == DONE);
    assign bus.BadTarget = (state_q == ERR);
endmodule

// File: tb/tb_branch_sequencer.sv
// Self-checking bench for branch_sequencer: a default-width instance for the
// PC behaviour and a CNT_W=4 instance for counter saturation.
module tb_branch_sequencer;
    logic Clk;
    logic Reset_n;

    int checks = 0;
    int errors = 0;

    logic [9:0] pc_exp_q[$];
    logic [3:0] cnt_exp_q[$];

    branch_sequencer_if #(.PC_W(10), .LUT_AW(4), .CNT_W(16)) bus();
    branch_sequencer_if #(.PC_W(10), .LUT_AW(4), .CNT_W(4))  bus4();

    branch_sequencer #(.PC_W(10), .LUT_AW(4), .MAX_LUT_IDX(8), .RESET_PC(0), .CNT_W(16)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .bus(bus)
    );

    branch_sequencer #(.PC_W(10), .LUT_AW(4), .MAX_LUT_IDX(8), .RESET_PC(0), .CNT_W(4)) dut4 (
        .Clk(Clk), .Reset_n(Reset_n), .bus(bus4)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.Start = 0; bus.Halt = 0; bus.BranchEn = 0; bus.BranchCond = 0;
        bus.BranchIdx = '0; bus.LutTarget = '0;
        bus4.Start = 0; bus4.Halt = 0; bus4.BranchEn = 0; bus4.BranchCond = 0;
        bus4.BranchIdx = '0; bus4.LutTarget = '0;
    endtask

    task automatic start_run();
        bus.Start = 1;
        tick();
        bus.Start = 0;
    endtask

    task automatic test_reset();
        logic [9:0] pc;
        checks++;
        if (bus.ProgCtr !== 10'h000 || bus.Running !== 0 || bus.Done !== 0 ||
            bus.BadTarget !== 0 || bus.CycleCnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_initial: pc=%h run=%b done=%b bad=%b cnt=%0d, want pc=000 flags=0 cnt=0",
                     bus.ProgCtr, bus.Running, bus.Done, bus.BadTarget, bus.CycleCnt);
        end
        #11 Reset_n = 1;
        tick();
        start_run();
        for (int i = 1; i <= 5; i++) pc_exp_q.push_back(10'(i));
        for (int i = 1; i <= 5; i++) begin
            tick();
            pc = pc_exp_q.pop_front();
            checks++;
            if (bus.ProgCtr !== pc) begin
                errors++;
                $display("FAIL reset_prerun_pc: got %h want %h", bus.ProgCtr, pc);
            end
        end
        // assert reset between clock edges and check without any edge
        #3 Reset_n = 0;
        #1;
        checks++;
        if (bus.ProgCtr !== 10'h000 || bus.Running !== 0 || bus.Done !== 0 ||
            bus.BadTarget !== 0 || bus.CycleCnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_async: pc=%h run=%b done=%b bad=%b cnt=%0d, want pc=000 flags=0 cnt=0",
                     bus.ProgCtr, bus.Running, bus.Done, bus.BadTarget, bus.CycleCnt);
        end
        #2 Reset_n = 1;
        tick();
        checks++;
        if (bus.Running !== 0 || bus.ProgCtr !== 10'h000) begin
            errors++;
            $display("FAIL reset_no_resume: run=%b pc=%h want run=0 pc=000", bus.Running, bus.ProgCtr);
        end
    endtask

    task automatic test_sequential();
        logic [9:0] pc;
        start_run();
        checks++;
        if (bus.Running !== 1 || bus.ProgCtr !== 10'h000 || bus.CycleCnt !== 16'd0) begin
            errors++;
            $display("FAIL seq_start: run=%b pc=%h cnt=%0d want run=1 pc=000 cnt=0",
                     bus.Running, bus.ProgCtr, bus.CycleCnt);
        end
        for (int i = 1; i <= 5; i++) begin
            pc_exp_q.push_back(10'(i));
            tick();
            pc = pc_exp_q.pop_front();
            checks++;
            if (bus.ProgCtr !== pc) begin
                errors++;
                $display("FAIL seq_pc: got %h want %h", bus.ProgCtr, pc);
            end
        end
        checks++;
        if (bus.CycleCnt !== 16'd5 || bus.Running !== 1) begin
            errors++;
            $display("FAIL seq_cnt: cnt=%0d run=%b want cnt=5 run=1", bus.CycleCnt, bus.Running);
        end
    endtask

    task automatic test_branch();
        logic [9:0] pc;
        bus.BranchEn = 1; bus.BranchCond = 1; bus.BranchIdx = 4'd3; bus.LutTarget = 10'h1A4;
        #1;
        checks++;
        if (bus.LutAddr !== 4'd3) begin
            errors++;
            $display("FAIL branch_lutaddr: got %0d want 3", bus.LutAddr);
        end
        pc_exp_q.push_back(10'h1A4);
        tick();
        pc = pc_exp_q.pop_front();
        checks++;
        if (bus.ProgCtr !== pc) begin
            errors++;
            $display("FAIL branch_taken: got %h want %h", bus.ProgCtr, pc);
        end
        bus.BranchCond = 0; bus.LutTarget = 10'h055;
        pc_exp_q.push_back(10'h1A5);
        tick();
        pc = pc_exp_q.pop_front();
        checks++;
        if (bus.ProgCtr !== pc) begin
            errors++;
            $display("FAIL branch_not_taken: got %h want %h", bus.ProgCtr, pc);
        end
        bus.BranchEn = 0;
    endtask

    task automatic test_bad_index();
        logic [9:0] pc;
        // index 8 is the last legal entry
        bus.BranchEn = 1; bus.BranchCond = 1; bus.BranchIdx = 4'd8; bus.LutTarget = 10'h0C0;
        pc_exp_q.push_back(10'h0C0);
        tick();
        pc = pc_exp_q.pop_front();
        checks++;
        if (bus.ProgCtr !== pc || bus.BadTarget !== 0) begin
            errors++;
            $display("FAIL bad_idx8_legal: pc=%h bad=%b want pc=%h bad=0", bus.ProgCtr, bus.BadTarget, pc);
        end
        bus.BranchIdx = 4'd9; bus.LutTarget = 10'h222;
        pc_exp_q.push_back(10'h0C0);
        tick();
        pc = pc_exp_q.pop_front();
        checks++;
        if (bus.ProgCtr !== pc || bus.BadTarget !== 1 || bus.Running !== 0) begin
            errors++;
            $display("FAIL bad_idx9: pc=%h bad=%b run=%b want pc=%h bad=1 run=0",
                     bus.ProgCtr, bus.BadTarget, bus.Running, pc);
        end
        pc_exp_q.push_back(10'h0C0);
        tick();
        pc = pc_exp_q.pop_front();
        checks++;
        if (bus.ProgCtr !== pc || bus.BadTarget !== 1) begin
            errors++;
            $display("FAIL bad_hold: pc=%h bad=%b want pc=%h bad=1", bus.ProgCtr, bus.BadTarget, pc);
        end
        clear_inputs();
        start_run();
        checks++;
        if (bus.Running !== 1 || bus.BadTarget !== 0 || bus.ProgCtr !== 10'h000 || bus.CycleCnt !== 16'd0) begin
            errors++;
            $display("FAIL bad_restart: run=%b bad=%b pc=%h cnt=%0d want run=1 bad=0 pc=000 cnt=0",
                     bus.Running, bus.BadTarget, bus.ProgCtr, bus.CycleCnt);
        end
    endtask

    task automatic test_halt();
        logic [9:0] pc;
        for (int i = 1; i <= 8; i++) tick();
        bus.Start = 1;
        pc_exp_q.push_back(10'h009);
        tick();
        bus.Start = 0;
        pc = pc_exp_q.pop_front();
        checks++;
        if (bus.ProgCtr !== pc || bus.Running !== 1) begin
            errors++;
            $display("FAIL halt_start_in_run: pc=%h run=%b want pc=%h run=1", bus.ProgCtr, bus.Running, pc);
        end
        for (int i = 1; i <= 7; i++) tick();
        checks++;
        if (bus.ProgCtr !== 10'h010) begin
            errors++;
            $display("FAIL halt_pre_pc: got %h want 010", bus.ProgCtr);
        end
        bus.Halt = 1; bus.BranchEn = 1; bus.BranchCond = 1; bus.BranchIdx = 4'd3; bus.LutTarget = 10'h1A4;
        pc_exp_q.push_back(10'h010);
        tick();
        pc = pc_exp_q.pop_front();
        checks++;
        if (bus.ProgCtr !== pc || bus.Done !== 1 || bus.Running !== 0 || bus.CycleCnt !== 16'd17) begin
            errors++;
            $display("FAIL halt_priority: pc=%h done=%b run=%b cnt=%0d want pc=%h done=1 run=0 cnt=17",
                     bus.ProgCtr, bus.Done, bus.Running, bus.CycleCnt, pc);
        end
        clear_inputs();
        bus.Halt = 1; bus.BranchIdx = 4'd12;
        pc_exp_q.push_back(10'h010);
        tick();
        pc = pc_exp_q.pop_front();
        checks++;
        if (bus.ProgCtr !== pc || bus.Done !== 1 || bus.CycleCnt !== 16'd17) begin
            errors++;
            $display("FAIL halt_hold: pc=%h done=%b cnt=%0d want pc=%h done=1 cnt=17",
                     bus.ProgCtr, bus.Done, bus.CycleCnt, pc);
        end
        clear_inputs();
    endtask

    task automatic test_wrap();
        logic [9:0] pc;
        start_run();
        bus.BranchEn = 1; bus.BranchCond = 1; bus.BranchIdx = 4'd1; bus.LutTarget = 10'h3FF;
        pc_exp_q.push_back(10'h3FF);
        tick();
        clear_inputs();
        pc_exp_q.push_back(10'h000);
        pc_exp_q.push_back(10'h001);
        pc = pc_exp_q.pop_front();
        checks++;
        if (bus.ProgCtr !== pc) begin
            errors++;
            $display("FAIL wrap_load: got %h want %h", bus.ProgCtr, pc);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            pc = pc_exp_q.pop_front();
            checks++;
            if (bus.ProgCtr !== pc) begin
                errors++;
                $display("FAIL wrap_inc: got %h want %h", bus.ProgCtr, pc);
            end
        end
    endtask

    task automatic test_saturation();
        logic [3:0] c;
        bus4.Start = 1;
        tick();
        bus4.Start = 0;
        for (int i = 1; i <= 20; i++) begin
            cnt_exp_q.push_back((i > 15) ? 4'hF : 4'(i));
            tick();
            c = cnt_exp_q.pop_front();
            checks++;
            if (bus4.CycleCnt !== c || bus4.Running !== 1) begin
                errors++;
                $display("FAIL sat_cnt: cycle %0d got %h want %h run=%b", i, bus4.CycleCnt, c, bus4.Running);
            end
        end
    endtask

    initial begin
        Reset_n = 0;
        clear_inputs();
        #1;
        test_reset();
        test_sequential();
        test_branch();
        test_bad_index();
        test_halt();
        test_wrap();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
